// File: rtl/gpio_lut_loader_if.sv
// Bus between the PS GPIO write port and a LUT loader instance.
// The master drives gpio_in and observes the LUT write port. The slave is the loader.
interface gpio_lut_loader_if;
   logic [31:0] gpio_in;
   logic [15:0] lut_waddr;
   logic [15:0] lut_wdata;
   logic        lut_wen;
   logic        seq_err;
   logic [15:0] write_count;

   modport master (
      output gpio_in,
      input  lut_waddr, lut_wdata, lut_wen, seq_err, write_count
   );

   modport slave (
      input  gpio_in,
      output lut_waddr, lut_wdata, lut_wen, seq_err, write_count
   );
endinterface

// File: rtl/gpio_lut_loader.sv
// Collects four GPIO byte writes (addr hi/lo, data hi/lo) into a single 16-bit LUT write.
// The w_clk strobe is asynchronous to clk, so it is synchronised and edge-detected before use.
//
// state | meaning
// S_AH  | waiting for LUT address high byte
// S_AL  | waiting for LUT address low byte
// S_DH  | waiting for LUT data high byte
// S_DL  | waiting for LUT data low byte; a valid byte here issues the write
module gpio_lut_loader #(
   parameter logic [15:0] ADDR_REG = 16'h0000,
   parameter logic [15:0] DATA_REG = 16'h0001,
   parameter logic [15:0] CTRL_REG = 16'h0002
) (
   input  logic                     clk,
   input  logic                     rst,
   gpio_lut_loader_if.slave         bus
);

   typedef enum logic [1:0] {
      S_AH = 2'd0,
      S_AL = 2'd1,
      S_DH = 2'd2,
      S_DL = 2'd3
   } state_t;

   if (ADDR_REG == DATA_REG) begin : g_reg_clash
      $error("gpio_lut_loader: ADDR_REG and DATA_REG must differ");
   end

   state_t      state_q, state_d;
   logic [31:0] hold_q, hold_d;
   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic        dly_q, dly_d;
   logic        seq_err_q, seq_err_d;
   logic        wen_q, wen_d;
   logic [15:0] waddr_q, waddr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] count_q, count_d;

   logic        evt;
   logic [15:0] gpio_addr;
   logic [7:0]  gpio_data;
   logic        unused_gpio;

   assign gpio_addr   = bus.gpio_in[15:0];
   assign gpio_data   = bus.gpio_in[23:16];
   assign unused_gpio = ^bus.gpio_in[31:25];
   assign evt         = sync2_q & ~dly_q;

   always_comb begin
      sync1_d   = bus.gpio_in[24];
      sync2_d   = sync1_q;
      dly_d     = sync2_q;
      state_d   = state_q;
      hold_d    = hold_q;
      seq_err_d = seq_err_q;
      wen_d     = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      count_d   = count_q;

      if (evt) begin
         // CTRL is checked first so it wins even if it aliases another register.
         if (gpio_addr == CTRL_REG) begin
            state_d   = S_AH;
            seq_err_d = 1'b0;
         end else if (gpio_addr == ADDR_REG) begin
            case (state_q)
               S_AH: begin
                  hold_d[31:24] = gpio_data;
                  state_d       = S_AL;
               end
               S_AL: begin
                  hold_d[23:16] = gpio_data;
                  state_d       = S_DH;
               end
               default: begin
                  // An address byte mid-data restarts the sequence with this byte as addr hi.
                  seq_err_d     = 1'b1;
                  hold_d[31:24] = gpio_data;
                  state_d       = S_AL;
               end
            endcase
         end else if (gpio_addr == DATA_REG) begin
            case (state_q)
               S_AH: begin
                  seq_err_d = 1'b1;
               end
               S_AL: begin
                  seq_err_d = 1'b1;
                  state_d   = S_AH;
               end
               S_DH: begin
                  hold_d[15:8] = gpio_data;
                  state_d      = S_DL;
               end
               default: begin
                  hold_d[7:0] = gpio_data;
                  state_d     = S_AH;
                  wen_d       = 1'b1;
                  waddr_d     = hold_q[31:16];
                  wdata_d     = {hold_q[15:8], gpio_data};
                  count_d     = count_q + 16'd1;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_AH;
         hold_q    <= '0;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         dly_q     <= 1'b0;
         seq_err_q <= 1'b0;
         wen_q     <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         dly_q     <= dly_d;
         seq_err_q <= seq_err_d;
         wen_q     <= wen_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         count_q   <= count_d;
      end
   end

   assign bus.lut_waddr   = waddr_q;
   assign bus.lut_wdata   = wdata_q;
   assign bus.lut_wen     = wen_q;
   assign bus.seq_err     = seq_err_q;
   assign bus.write_count = count_q;

endmodule

// File: tb/tb_gpio_lut_loader.sv
// Directed bench for gpio_lut_loader: a byte-sequence model predicts every LUT write,
// and a per-cycle monitor compares the write port against it.
module tb_gpio_lut_loader;
   localparam logic [15:0] AREG = 16'h0000;
   localparam logic [15:0] DREG = 16'h0001;
   localparam logic [15:0] CREG = 16'h0002;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   gpio_lut_loader_if bus();

   gpio_lut_loader #(
      .ADDR_REG(AREG),
      .DATA_REG(DREG),
      .CTRL_REG(CREG)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   // Model: position within the 4-byte sequence, collected bytes, expected writes.
   int          m_pos;
   logic [7:0]  m_byte [4];
   logic        m_err;
   logic [31:0] expq [$];
   logic [15:0] m_waddr;
   logic [15:0] m_wdata;
   logic [15:0] m_cnt;
   int          wen_cycles = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pos   = 0;
      m_err   = 1'b0;
      m_waddr = 16'h0;
      m_wdata = 16'h0;
      m_cnt   = 16'h0;
      for (int i = 0; i < 4; i++) m_byte[i] = 8'h0;
      expq.delete();
   endtask

   task automatic model_write(input logic [15:0] a, input logic [7:0] d);
      if (a == CREG) begin
         m_pos = 0;
         m_err = 1'b0;
      end else if (a == AREG) begin
         if (m_pos < 2) begin
            m_byte[m_pos] = d;
            m_pos++;
         end else begin
            m_err     = 1'b1;
            m_byte[0] = d;
            m_pos     = 1;
         end
      end else if (a == DREG) begin
         if (m_pos < 2) begin
            m_err = 1'b1;
            m_pos = 0;
         end else begin
            m_byte[m_pos] = d;
            if (m_pos == 3) begin
               expq.push_back({m_byte[0], m_byte[1], m_byte[2], m_byte[3]});
               m_pos = 0;
            end else begin
               m_pos = 3;
            end
         end
      end
   endtask

   // Per-cycle monitor of the LUT write port.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.lut_wen === 1'b1) begin
            wen_cycles++;
            if (expq.size() == 0) begin
               check("unexpected_wen", {31'b0, bus.lut_wen}, 32'd0);
            end else begin
               logic [31:0] e;
               e       = expq.pop_front();
               m_waddr = e[31:16];
               m_wdata = e[15:0];
               m_cnt   = m_cnt + 16'd1;
            end
         end
         check("lut_waddr", {16'b0, bus.lut_waddr}, {16'b0, m_waddr});
         check("lut_wdata", {16'b0, bus.lut_wdata}, {16'b0, m_wdata});
         check("write_count", {16'b0, bus.write_count}, {16'b0, m_cnt});
      end
   end

   task automatic gpio_write(input logic [15:0] a, input logic [7:0] d, input int hi);
      @(negedge clk);
      bus.gpio_in = {8'h00, 1'b0, d, a};
      model_write(a, d);
      @(negedge clk);
      bus.gpio_in[24] = 1'b1;
      repeat (hi) @(negedge clk);
      bus.gpio_in[24] = 1'b0;
      repeat (3) @(negedge clk);
      check("pending_wen", expq.size(), 32'd0);
      check("seq_err", {31'b0, bus.seq_err}, {31'b0, m_err});
   endtask

   task automatic seq4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3, input int hi);
      gpio_write(AREG, b0, hi);
      gpio_write(AREG, b1, hi);
      gpio_write(DREG, b2, hi);
      gpio_write(DREG, b3, hi);
   endtask

   task automatic pin(input string tag, input logic [15:0] wa, input logic [15:0] wd,
                      input logic [15:0] cnt, input logic err);
      check({tag, "_waddr"}, {16'b0, bus.lut_waddr}, {16'b0, wa});
      check({tag, "_wdata"}, {16'b0, bus.lut_wdata}, {16'b0, wd});
      check({tag, "_count"}, {16'b0, bus.write_count}, {16'b0, cnt});
      check({tag, "_err"}, {31'b0, bus.seq_err}, {31'b0, err});
   endtask

   initial begin
      bus.gpio_in = 32'h0;
      model_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_wen", {31'b0, bus.lut_wen}, 32'd0);
      pin("rst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // basic sequence with negative-looking values
      seq4(8'hFF, 8'hFB, 8'h03, 8'hE8, 3);
      pin("t1", 16'hFFFB, 16'h03E8, 16'd1, 1'b0);

      // long w_clk hold must give a single event
      gpio_write(AREG, 8'h12, 10);
      gpio_write(AREG, 8'h34, 3);
      gpio_write(DREG, 8'h56, 3);
      gpio_write(DREG, 8'h78, 3);
      pin("t2", 16'h1234, 16'h5678, 16'd2, 1'b0);

      // address bytes arriving during the data phase restart the sequence
      gpio_write(AREG, 8'h01, 3);
      gpio_write(AREG, 8'h02, 3);
      gpio_write(DREG, 8'h03, 3);
      seq4(8'h0A, 8'h0B, 8'h0C, 8'h0D, 3);
      pin("t3", 16'h0A0B, 16'h0C0D, 16'd3, 1'b1);

      // CTRL clears the error; unrelated registers are ignored mid-sequence
      gpio_write(CREG, 8'h00, 3);
      pin("t4c", 16'h0A0B, 16'h0C0D, 16'd3, 1'b0);
      gpio_write(AREG, 8'h21, 3);
      gpio_write(16'h00FF, 8'h99, 3);
      gpio_write(AREG, 8'h43, 3);
      gpio_write(DREG, 8'h65, 3);
      gpio_write(16'h00FF, 8'h77, 3);
      gpio_write(DREG, 8'h87, 3);
      pin("t4", 16'h2143, 16'h6587, 16'd4, 1'b0);

      // data bytes while expecting address bytes; error stays sticky across a good write
      gpio_write(DREG, 8'h55, 3);
      gpio_write(AREG, 8'h11, 3);
      gpio_write(DREG, 8'h22, 3);
      seq4(8'hA5, 8'h5A, 8'h80, 8'h01, 1);
      pin("t7", 16'hA55A, 16'h8001, 16'd5, 1'b1);

      // reset mid-sequence discards partial bytes
      gpio_write(AREG, 8'h77, 3);
      gpio_write(AREG, 8'h66, 3);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      seq4(8'h11, 8'h22, 8'h33, 8'h44, 3);
      pin("t5", 16'h1122, 16'h3344, 16'd1, 1'b0);

      // back-to-back sequences at minimum w_clk width
      for (int i = 0; i < 20; i++) begin
         logic [7:0] v;
         v = 8'(i * 13 + 7);
         seq4(v, ~v, 8'(v + 8'd1), 8'(v ^ 8'h5C), 1);
      end
      check("burst_count", {16'b0, bus.write_count}, 32'd21);
      check("wen_cycles", wen_cycles, 32'd26);

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
